// File: rtl/apb_pkg.sv
// Shared definitions for the APB slave memory: FSM state encoding,
// default geometry and the error-cause codes.
package apb_pkg;

  localparam int unsigned APB_ADDR_W_DEF = 9;
  localparam int unsigned APB_DATA_W_DEF = 8;
  localparam int unsigned APB_DEPTH_DEF  = 256;

  localparam logic [7:0] APB_ERR_CNT_MAX = 8'hFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_RANGE  = 2'd1,
    ERR_ALIGN  = 2'd2,
    ERR_RDONLY = 2'd3
  } apb_err_e;

  // Number of byte-offset bits inside one data word.
  function automatic int unsigned apb_offs_bits(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W storage with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
module apb_mem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wstrb,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Byte-lane write: only lanes whose strobe is set are updated.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave fronting a byte-writable memory, with programmable wait states,
// an optional read-only upper region and a saturating error counter.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W_DEF,
  parameter int unsigned DATA_W  = APB_DATA_W_DEF,
  parameter int unsigned DEPTH   = APB_DEPTH_DEF,
  parameter int unsigned RO_BASE = DEPTH
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_W-1:0]     PADDR,
  input  logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W/8-1:0]   PSTRB,
  input  logic [3:0]            wait_cfg,
  output logic [DATA_W-1:0]     PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [7:0]            err_count
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFFS_W = apb_offs_bits(DATA_W);
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'((64'd1 << OFFS_W) - 64'd1);

  apb_state_e          r_state;
  apb_state_e          w_next_state;

  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_strb;
  logic [3:0]          r_wait;
  logic [7:0]          r_err_count;

  logic                w_setup;
  logic                w_complete;
  logic [ADDR_W-1:0]   w_word_idx;
  apb_err_e            w_err_cause;
  logic                w_err;
  logic                w_mem_we;
  logic [MEM_AW-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_rdata;

  assign w_setup    = PSEL & ~PENABLE;
  // Completion needs PSEL still high; a dropped PSEL is an abort, not a completion.
  assign w_complete = (r_state == ST_ACCESS) && PSEL && (r_wait == '0);
  assign w_word_idx = r_addr >> OFFS_W;

  // Classify the latched transfer; misalignment takes priority over range.
  always_comb begin
    w_err_cause = ERR_NONE;
    if ((r_addr & OFFS_MASK) != '0) begin
      w_err_cause = ERR_ALIGN;
    end else if (32'(w_word_idx) >= DEPTH) begin
      w_err_cause = ERR_RANGE;
    end else if (r_write && (32'(w_word_idx) >= RO_BASE)) begin
      w_err_cause = ERR_RDONLY;
    end
  end

  assign w_err      = (w_err_cause != ERR_NONE);
  assign w_mem_we   = w_complete && r_write && !w_err;
  assign w_mem_addr = MEM_AW'(w_word_idx);

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: setup enters ACCESS, completion or abort returns to IDLE.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_setup) begin
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!PSEL || (r_wait == '0)) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs are driven only during a completion cycle, zero otherwise.
  always_comb begin
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    if (w_complete) begin
      PREADY  = 1'b1;
      PSLVERR = w_err;
      if (!w_err && !r_write) begin
        PRDATA = w_mem_rdata;
      end
    end
  end

  // Transfer capture, wait-state countdown and error counting.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_wait      <= '0;
      r_err_count <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_setup) begin
        r_addr  <= PADDR;
        r_write <= PWRITE;
        r_wdata <= PWDATA;
        r_strb  <= PSTRB;
        r_wait  <= wait_cfg;
      end else if ((r_state == ST_ACCESS) && PSEL && (r_wait != '0)) begin
        r_wait <= r_wait - 4'd1;
      end
      if (w_complete && w_err && (r_err_count != APB_ERR_CNT_MAX)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign err_count = r_err_count;

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (MEM_AW)
  ) u_mem (
    .i_clk   (PCLK),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (r_wdata),
    .i_wstrb (r_strb),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem (32-bit data, 64 words, words 48.. read-only).
module tb_apb_slave_mem;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned RO_BASE = 48;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic              PSEL, PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [3:0]        PSTRB;
  logic [3:0]        wait_cfg;
  logic [31:0]       PRDATA;
  logic              PREADY, PSLVERR;
  logic [7:0]        err_count;

  apb_slave_mem #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .RO_BASE (RO_BASE)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .wait_cfg  (wait_cfg),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .err_count (err_count)
  );

  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    bit          err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  // Reference model: byte-level memory with knowledge of which bytes were written.
  logic [7:0] m_mem   [DEPTH][4];
  bit         m_known [DEPTH][4];
  int         m_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: tracks cycles since setup and checks each completion against the scoreboard.
  int mon_lat = 0;
  always @(negedge PCLK) begin
    if (PRESETn === 1'b1) begin
      if (PSEL && !PENABLE) mon_lat = 1;
      else if (mon_lat < 1000) mon_lat++;
      if (PREADY === 1'b1) begin
        if (sb.size() == 0) begin
          chk("pready_unexpected", 32'(PREADY), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pslverr", 32'(PSLVERR), 32'(e.err));
          chk("prdata", PRDATA & e.mask, e.data & e.mask);
          chk("latency", 32'(mon_lat), 32'(e.lat));
        end
      end else begin
        chk("quiet_pslverr", 32'(PSLVERR), 32'd0);
        chk("quiet_prdata", PRDATA, 32'd0);
      end
    end
  end

  // mode: 0 = normal, 1 = drop PSEL mid-access, 2 = pulse reset mid-access.
  task automatic xfer(input bit w, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int wt, input int mode);
    int   ai, idx;
    bit   err;
    exp_t e;
    bit   done;
    ai  = int'(a);
    idx = ai / 4;
    err = (ai % 4 != 0) || (idx >= DEPTH) || (w && idx >= RO_BASE);
    if (mode == 0) begin
      e.err  = err;
      e.lat  = 2 + wt;
      e.data = 32'd0;
      e.mask = 32'hFFFF_FFFF;
      if (!err && w) begin
        e.mask = 32'd0;
        for (int b = 0; b < 4; b++) begin
          if (s[b]) begin
            m_mem[idx][b]   = d[b*8 +: 8];
            m_known[idx][b] = 1'b1;
          end
        end
      end else if (!err) begin
        for (int b = 0; b < 4; b++) begin
          e.data[b*8 +: 8] = m_mem[idx][b];
          e.mask[b*8 +: 8] = m_known[idx][b] ? 8'hFF : 8'h00;
        end
      end
      if (err && m_err < 255) m_err++;
      sb.push_back(e);
    end
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a;
    PWDATA = d; PSTRB = s; wait_cfg = 4'(wt);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (mode == 0) begin
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge PCLK);
        if (PREADY === 1'b1) begin
          @(posedge PCLK); #1;
          done = 1'b1;
        end
      end
      if (!done) chk("pready_timeout", 32'(done), 32'd1);
      PSEL = 1'b0; PENABLE = 1'b0;
      chk("err_count", 32'(err_count), 32'(m_err));
    end else if (mode == 1) begin
      repeat (2) @(posedge PCLK);
      #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      chk("err_count_abort", 32'(err_count), 32'(m_err));
    end else begin
      repeat (2) @(posedge PCLK);
      #1;
      PRESETn = 1'b0;
      PSEL = 1'b0; PENABLE = 1'b0;
      m_err = 0;
      @(negedge PCLK);
      chk("rst_pready", 32'(PREADY), 32'd0);
      chk("rst_pslverr", 32'(PSLVERR), 32'd0);
      chk("rst_prdata", PRDATA, 32'd0);
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      chk("err_count_reset", 32'(err_count), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    int r;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; wait_cfg = '0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("reset_pready", 32'(PREADY), 32'd0);
    chk("reset_pslverr", 32'(PSLVERR), 32'd0);
    chk("reset_prdata", PRDATA, 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    idle(2);

    // Fill the writable region back-to-back.
    for (int i = 0; i < int'(RO_BASE); i++)
      xfer(1'b1, ADDR_W'(i * 4), $urandom, 4'hF, 0, 0);

    // Write then immediately read the same word.
    xfer(1'b1, 9'h010, 32'h0000_00A5, 4'hF, 0, 0);
    xfer(1'b0, 9'h010, 32'h0, 4'h0, 0, 0);
    idle(1);
    xfer(1'b0, 9'h010, 32'h0, 4'hF, 3, 0);
    idle(1);

    // Partial strobes: expected 0xFF00FF00.
    xfer(1'b1, 9'h004, 32'hFFFF_FFFF, 4'hF, 0, 0);
    xfer(1'b1, 9'h004, 32'h0000_0000, 4'b0101, 1, 0);
    xfer(1'b0, 9'h004, 32'h0, 4'h0, 0, 0);
    idle(1);

    // Misaligned and out-of-range reads, then confirm memory untouched.
    xfer(1'b0, 9'h002, 32'h0, 4'h0, 0, 0);
    xfer(1'b0, 9'h100, 32'h0, 4'h0, 2, 0);
    chk("err_count_two", 32'(err_count), 32'd2);
    xfer(1'b0, 9'h004, 32'h0, 4'h0, 0, 0);
    xfer(1'b1, 9'h0FE, 32'h1234_5678, 4'hF, 0, 0);
    xfer(1'b0, 9'h0FC, 32'h0, 4'h0, 0, 0);

    // Read-only region: write rejected, read accepted.
    xfer(1'b1, 9'h0C0, 32'h5555_AAAA, 4'hF, 0, 0);
    xfer(1'b0, 9'h0C0, 32'h0, 4'h0, 0, 0);
    xfer(1'b0, 9'h0BC, 32'h0, 4'h0, 0, 0);

    // Access phase without setup from IDLE is ignored.
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 9'h010;
    for (int c = 0; c < 3; c++) begin
      @(negedge PCLK);
      chk("ignored_pready", 32'(PREADY), 32'd0);
    end
    idle(1);

    // Abort by PSEL drop and by reset; following transfers must start from IDLE.
    xfer(1'b1, 9'h020, 32'hDEAD_BEEF, 4'hF, 5, 1);
    xfer(1'b0, 9'h020, 32'h0, 4'h0, 0, 0);
    xfer(1'b1, 9'h024, 32'hCAFE_F00D, 4'hF, 5, 2);
    idle(1);
    xfer(1'b0, 9'h024, 32'h0, 4'h0, 1, 0);
    xfer(1'b0, 9'h100, 32'h0, 4'h0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = ADDR_W'($urandom_range(0, 511) | 1);
      else if (r == 1) a = ADDR_W'($urandom_range(DEPTH, 127) * 4);
      else             a = ADDR_W'($urandom_range(0, DEPTH - 1) * 4);
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
           int'($urandom_range(0, 3)), 0);
      if ($urandom_range(0, 9) < 3) idle(int'($urandom_range(0, 2)));
    end

    // Drive the error counter into saturation.
    for (int i = 0; i < 260; i++)
      xfer(1'b0, 9'h101, 32'h0, 4'h0, 0, 0);
    chk("err_count_sat", 32'(err_count), 32'd255);

    idle(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 Parameter ADDR_W, 9, PADDR width in bits.
REQ-002 Parameter DATA_W, 8, PWDATA/PRDATA width; SHALL be 8, 16 or 32.
REQ-003 Parameter DEPTH, 256, number of DATA_W-bit words; SHALL be ≤ 2^(ADDR_W-log2(DATA_W/8)).
REQ-004 Parameter RO_BASE, DEPTH, first read-only word index; RO_BASE = DEPTH means no read-only region.
REQ-005 PCLK input 1 -- the single clock; all logic on its rising edge.
REQ-006 PRESETn input 1 -- reset, asynchronous, active-low.
REQ-007 PSEL input 1 -- slave select.
REQ-008 PENABLE input 1 -- access phase.
REQ-009 PWRITE input 1 -- 1 = write, 0 = read.
REQ-010 PADDR input ADDR_W -- byte address.
REQ-011 PWDATA input DATA_W -- write data.
REQ-012 PSTRB input DATA_W/8 -- byte write strobes.
REQ-013 wait_cfg input 4 -- wait states to insert; sampled in setup phase.
REQ-014 PRDATA output DATA_W -- read data, valid only while PREADY=1.
REQ-015 PREADY output 1 -- transfer completion.
REQ-016 PSLVERR output 1 -- error, valid only while PREADY=1.
REQ-017 err_count output 8 -- saturating count of PSLVERR completions.

Function
REQ-018 FSM states IDLE, ACCESS; the encoding is taken from the shared package.
REQ-019 In IDLE, PSEL=1 and PENABLE=0 (setup) SHALL latch PADDR, PWRITE, PWDATA, PSTRB and wait_cfg, load wait counter = wait_cfg, and move to ACCESS.
REQ-020 In IDLE, PSEL=1 and PENABLE=1 SHALL be ignored (no state change, PREADY=0).
REQ-021 In ACCESS with counter ≠ 0: PREADY=0; counter decrements each cycle.
REQ-022 In ACCESS with counter = 0: PREADY=1 combinationally; the next edge completes the transfer and returns to IDLE. Total latency from setup = 2 + wait_cfg cycles.
REQ-023 Word index = PADDR >> log2(DATA_W/8).
REQ-024 Error conditions: word index ≥ DEPTH; misaligned PADDR (low log2(DATA_W/8) bits ≠ 0); write with word index ≥ RO_BASE.
REQ-025 On error, the completion cycle SHALL assert PSLVERR=1 and PRDATA=0, perform no write, and increment err_count, saturating at 255.
REQ-026 Valid write SHALL update only the bytes whose PSTRB bit is 1, on the completion edge.
REQ-027 Valid read SHALL present the stored word on PRDATA during the completion cycle. A PSTRB value on a read SHALL be ignored.
REQ-028 PSEL deasserted while in ACCESS SHALL abort the transfer: return to IDLE next edge, no write, no err_count change, PREADY=0.
REQ-029 Back-to-back transfers (setup directly after completion) SHALL be accepted with no idle cycle; a read directly after a write to the same word SHALL return the new data.
REQ-030 Outside a completion cycle: PREADY=0, PSLVERR=0, PRDATA=0.

Reset
REQ-031 While PRESETn=0: state=IDLE, counter=0, latched transfer registers=0, err_count=0, PREADY=0, PSLVERR=0, PRDATA=0.
REQ-032 Memory contents are not reset and are undefined until written.
REQ-033 Reset asserted mid-ACCESS SHALL abandon the transfer with no write.

Structure
REQ-034 Shared package apb_pkg SHALL hold the state enum, the default parameter values and the error-cause constants.
REQ-035 Storage SHALL be one sub-module, apb_mem_array: DEPTH×DATA_W, byte-write-enabled, asynchronous read.
REQ-036 Target size is 120–400 lines of RTL across both modules.

Verification
REQ-037 Defaults; write 0xA5 to 0x010 with wait_cfg=0, then read 0x010 → PREADY 2 cycles after setup; PRDATA=0xA5; PSLVERR=0.
REQ-038 wait_cfg=3, read → PREADY low for 3 ACCESS cycles, high on the 4th; latency 5 cycles.
REQ-039 DATA_W=32, DEPTH=64; write 0xFFFFFFFF, then write 0x00000000 with PSTRB=0101 to 0x004; read 0x004 → 0xFF00FF00.
REQ-040 DATA_W=32; read 0x002 (misaligned), then 0x100 (out of range) → PSLVERR=1 both times; PRDATA=0; err_count=2; memory unchanged.
REQ-041 RO_BASE=128, DEPTH=256; write to 0x0C0 → PSLVERR=1, no write; read 0x0C0 → PSLVERR=0.
REQ-042 PSEL dropped mid-ACCESS (wait_cfg=5), and separately PRESETn pulsed mid-ACCESS → no write; FSM IDLE; err_count unchanged by abort and 0 after reset.
